// File: rtl/reg_bank.sv
// Parametrised scratch/configuration register bank with byte-lane write
// strobes, selectable read-during-write policy and a command-started clear sweep.
module reg_bank #(
  parameter  int DATA_W      = 8,
  parameter  int DEPTH       = 4,
  parameter  int WRITE_FIRST = 0,
  localparam int ADDR_W      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read_enable,
  input  logic                write_enable,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   write_data,
  input  logic [DATA_W/8-1:0] write_strb,
  input  logic                clear_start,
  output logic [DATA_W-1:0]   read_data,
  output logic                read_active,
  output logic                busy,
  output logic                access_error
);

  localparam int LANES = DATA_W / 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DATA_W-1:0]   read_data_q, read_data_d;
  logic                read_active_q, read_active_d;
  logic                access_error_q, access_error_d;
  logic [DATA_W-1:0]   old_word_s;
  logic [DATA_W-1:0]   merged_word_s;

  // Byte-lane merge: strobed lanes take the new data, the rest keep the old word.
  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [LANES-1:0]  strb
  );
    logic [DATA_W-1:0] result;
    result = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (strb[i]) begin
        result[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        result[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return result;
  endfunction

  // Addressed word and its strobe-merged version, shared by the write and write-first read.
  always_comb begin
    old_word_s    = mem_q[address];
    merged_word_s = merge_lanes(old_word_s, write_data, write_strb);
  end

  // Next-state, storage update and registered-output computation.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mem_d          = mem_q;
    read_data_d    = read_data_q;
    read_active_d  = 1'b0;
    access_error_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (write_enable) begin
          mem_d[address] = merged_word_s;
        end else begin
          mem_d[address] = old_word_s;
        end
        if (read_enable) begin
          read_active_d = 1'b1;
          if ((WRITE_FIRST != 0) && write_enable) begin
            read_data_d = merged_word_s;
          end else begin
            read_data_d = old_word_s;
          end
        end else begin
          read_active_d = 1'b0;
        end
        if (clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        // Requests are refused while sweeping; flag them for exactly one cycle.
        mem_d[cnt_q]   = {DATA_W{1'b0}};
        access_error_d = read_enable | write_enable;
        cnt_d          = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State, storage and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= {ADDR_W{1'b0}};
      read_data_q    <= {DATA_W{1'b0}};
      read_active_q  <= 1'b0;
      access_error_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      read_data_q    <= read_data_d;
      read_active_q  <= read_active_d;
      access_error_q <= access_error_d;
      mem_q          <= mem_d;
    end
  end

  assign read_data    = read_data_q;
  assign read_active  = read_active_q;
  assign busy         = (state_q == ST_CLEAR);
  assign access_error = access_error_q;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: two builds (old-data and write-first) share
// stimulus and are compared against a queue-free behavioural model.
module tb_reg_bank;

  localparam int DW = 32;
  localparam int DP = 4;

  logic          clk;
  logic          rst;
  logic          read_enable;
  logic          write_enable;
  logic [1:0]    address;
  logic [DW-1:0] write_data;
  logic [3:0]    write_strb;
  logic          clear_start;
  logic [DW-1:0] rd0, rd1;
  logic          ra0, ra1, busy0, busy1, ae0, ae1;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: storage, remaining sweep cycles, expected outputs
  logic [DW-1:0] m_mem [DP];
  int            m_left;
  logic [DW-1:0] exp_rd0, exp_rd1;
  logic          exp_ra, exp_ae, exp_busy;

  reg_bank #(.DATA_W(DW), .DEPTH(DP), .WRITE_FIRST(0)) dut0 (
    .clk(clk), .rst(rst), .read_enable(read_enable), .write_enable(write_enable),
    .address(address), .write_data(write_data), .write_strb(write_strb),
    .clear_start(clear_start), .read_data(rd0), .read_active(ra0),
    .busy(busy0), .access_error(ae0));

  reg_bank #(.DATA_W(DW), .DEPTH(DP), .WRITE_FIRST(1)) dut1 (
    .clk(clk), .rst(rst), .read_enable(read_enable), .write_enable(write_enable),
    .address(address), .write_data(write_data), .write_strb(write_strb),
    .clear_start(clear_start), .read_data(rd1), .read_active(ra1),
    .busy(busy1), .access_error(ae1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model, clock, and settle.
  task automatic step(input logic r, input logic re, input logic we, input logic [1:0] a,
                      input logic [DW-1:0] wd, input logic [3:0] st, input logic cs);
    logic [DW-1:0] old, mask, merged;
    rst = r; read_enable = re; write_enable = we; address = a;
    write_data = wd; write_strb = st; clear_start = cs;
    if (r) begin
      for (int i = 0; i < DP; i++) m_mem[i] = 32'h0;
      m_left = 0; exp_rd0 = 32'h0; exp_rd1 = 32'h0; exp_ra = 1'b0; exp_ae = 1'b0;
    end else if (m_left > 0) begin
      exp_ae = re | we;
      exp_ra = 1'b0;
      m_mem[DP - m_left] = 32'h0;
      m_left = m_left - 1;
    end else begin
      exp_ae = 1'b0;
      old  = m_mem[a];
      mask = 32'h0;
      for (int b = 0; b < 4; b++) if (st[b]) mask = mask | (32'hFF << (8 * b));
      merged = (old & ~mask) | (wd & mask);
      exp_ra = re;
      if (re) begin
        exp_rd0 = old;
        exp_rd1 = we ? merged : old;
      end
      if (we) m_mem[a] = merged;
      if (cs) m_left = DP;
    end
    exp_busy = (m_left > 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 1'b0);
    n_checks++;
    if (busy0 !== 1'b0 || ra0 !== 1'b0 || ae0 !== 1'b0 || rd0 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b ra=%b ae=%b rd=%h, required 0 0 0 0", busy0, ra0, ae0, rd0);
    end
    for (int i = 0; i < DP; i++) begin
      step(1'b0, 1'b1, 1'b0, 2'(i), 32'h0, 4'h0, 1'b0);
      n_checks++;
      if (rd0 !== 32'h0 || ra0 !== 1'b1 || rd1 !== 32'h0 || ra1 !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_read[%0d]: rd=%h ra=%b, required 0 and 1", i, rd0, ra0);
      end
    end
    idle();
    n_checks++;
    if (ra0 !== 1'b0 || ra1 !== 1'b0) begin
      n_fail++;
      $display("FAIL read_active_idle: ra=%b/%b, required 0", ra0, ra1);
    end
  endtask

  task automatic test_strobe();
    step(1'b0, 1'b0, 1'b1, 2'd2, 32'hAABBCCDD, 4'b1111, 1'b0);
    step(1'b0, 1'b0, 1'b1, 2'd2, 32'h11223344, 4'b0101, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2'd2, 32'h0, 4'h0, 1'b0);
    n_checks++;
    if (rd0 !== 32'hAA22CC44 || rd1 !== 32'hAA22CC44) begin
      n_fail++;
      $display("FAIL strobe_merge: rd=%h/%h, required aa22cc44", rd0, rd1);
    end
    step(1'b0, 1'b0, 1'b1, 2'd2, 32'hFFFFFFFF, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2'd2, 32'h0, 4'h0, 1'b0);
    n_checks++;
    if (rd0 !== 32'hAA22CC44) begin
      n_fail++;
      $display("FAIL strobe_zero_noop: rd=%h, required aa22cc44", rd0);
    end
  endtask

  task automatic test_rdw();
    step(1'b0, 1'b0, 1'b1, 2'd1, 32'h55, 4'b1111, 1'b0);
    step(1'b0, 1'b1, 1'b1, 2'd1, 32'h99, 4'b1111, 1'b0);
    n_checks++;
    if (rd0 !== 32'h55 || rd1 !== 32'h99) begin
      n_fail++;
      $display("FAIL rdw_policy: rd_wf0=%h rd_wf1=%h, required 55 and 99", rd0, rd1);
    end
    step(1'b0, 1'b1, 1'b0, 2'd1, 32'h0, 4'h0, 1'b0);
    n_checks++;
    if (rd0 !== 32'h99 || rd1 !== 32'h99) begin
      n_fail++;
      $display("FAIL rdw_after: rd=%h/%h, required 99", rd0, rd1);
    end
  endtask

  task automatic test_clear_sweep();
    int busy_cycles;
    logic [DW-1:0] held;
    for (int i = 0; i < DP; i++) step(1'b0, 1'b0, 1'b1, 2'(i), 32'(i + 1), 4'hF, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2'd3, 32'h0, 4'h0, 1'b1);
    held = rd0;
    busy_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      if (busy0 !== 1'b1) break;
      busy_cycles++;
      step(1'b0, (i == 1), 1'b0, 2'd0, 32'h0, 4'h0, 1'b0);
      if (i == 1) begin
        n_checks++;
        if (ae0 !== 1'b1 || ra0 !== 1'b0 || rd0 !== held || ae1 !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_read: ae=%b ra=%b rd=%h, required 1 0 %h", ae0, ra0, rd0, held);
        end
      end
    end
    n_checks++;
    if (busy_cycles !== DP) begin
      n_fail++;
      $display("FAIL busy_length: %0d cycles, required %0d", busy_cycles, DP);
    end
    for (int i = 0; i < DP; i++) begin
      step(1'b0, 1'b1, 1'b0, 2'(i), 32'h0, 4'h0, 1'b0);
      n_checks++;
      if (rd0 !== 32'h0 || ra0 !== 1'b1 || ae0 !== 1'b0) begin
        n_fail++;
        $display("FAIL post_clear[%0d]: rd=%h ra=%b ae=%b, required 0 1 0", i, rd0, ra0, ae0);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    for (int i = 0; i < DP; i++) step(1'b0, 1'b0, 1'b1, 2'(i), 32'hC0DE0000 + 32'(i), 4'hF, 1'b0);
    step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 1'b1);
    idle();
    step(1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 4'h0, 1'b0);
    n_checks++;
    if (busy0 !== 1'b0 || ae0 !== 1'b0 || ra0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_sweep: busy=%b ae=%b ra=%b, required 0 0 0", busy0, ae0, ra0);
    end
    step(1'b0, 1'b1, 1'b1, 2'd3, 32'hA5A5A5A5, 4'hF, 1'b0);
    n_checks++;
    if (rd0 !== 32'h0 || rd1 !== 32'hA5A5A5A5 || ra0 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_roundtrip_rdw: rd=%h/%h, required 0 and a5a5a5a5", rd0, rd1);
    end
    for (int i = 0; i < DP; i++) begin
      step(1'b0, 1'b1, 1'b0, 2'(i), 32'h0, 4'h0, 1'b0);
      n_checks++;
      if (rd0 !== ((i == 3) ? 32'hA5A5A5A5 : 32'h0)) begin
        n_fail++;
        $display("FAIL reset_contents[%0d]: rd=%h", i, rd0);
      end
    end
  endtask

  task automatic test_back_to_back();
    int busy_cycles;
    step(1'b0, 1'b0, 1'b1, 2'd3, 32'h7E, 4'hF, 1'b1);
    busy_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      if (busy0 !== 1'b1) break;
      busy_cycles++;
      step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0, (i == 0) || (i == DP - 1));
    end
    n_checks++;
    if (busy_cycles !== DP) begin
      n_fail++;
      $display("FAIL clear_during_busy: busy %0d cycles, required %0d", busy_cycles, DP);
    end
    step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 1'b1);
    n_checks++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back_start: busy=%b, required 1", busy0);
    end
    for (int i = 0; i < DP; i++) idle();
    step(1'b0, 1'b1, 1'b0, 2'd3, 32'h0, 4'h0, 1'b0);
    n_checks++;
    if (rd0 !== 32'h0 || ra0 !== 1'b1 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_with_write: rd=%h ra=%b busy=%b, required 0 1 0", rd0, ra0, busy0);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 79) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           2'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)),
           ($urandom_range(0, 11) == 0));
      n_checks++;
      if (rd0 !== exp_rd0 || ra0 !== exp_ra || busy0 !== exp_busy || ae0 !== exp_ae) begin
        n_fail++;
        $display("FAIL random_wf0[%0d]: rd=%h ra=%b busy=%b ae=%b, required %h %b %b %b",
                 n, rd0, ra0, busy0, ae0, exp_rd0, exp_ra, exp_busy, exp_ae);
      end
      n_checks++;
      if (rd1 !== exp_rd1 || ra1 !== exp_ra || busy1 !== exp_busy || ae1 !== exp_ae) begin
        n_fail++;
        $display("FAIL random_wf1[%0d]: rd=%h ra=%b busy=%b ae=%b, required %h %b %b %b",
                 n, rd1, ra1, busy1, ae1, exp_rd1, exp_ra, exp_busy, exp_ae);
      end
    end
  endtask

  initial begin
    rst = 1'b1; read_enable = 1'b0; write_enable = 1'b0; address = 2'd0;
    write_data = 32'h0; write_strb = 4'h0; clear_start = 1'b0;
    test_reset();
    test_strobe();
    test_rdw();
    test_clear_sweep();
    test_reset_mid_sweep();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
